multi_cycle_ctrl: RTL

Multi-cycle control unit for the CPU. It sequences each instruction through the IF/ID/EXE/MEM/WB states and drives ALUSrcA, ALUSrcB and ALUOp to the ALU, plus the PC, IR, register-file and data-memory enables. It sits beside the ALU and register file and consumes opcode/funct from the instruction register and zero from the ALU.

---
 rtl/mips_ctrl_pkg.sv | 51 +++++
 rtl/ctrl_decode.sv | 73 +++++++
 rtl/multi_cycle_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - state encoding, opcode/funct constants, ALUOp and PCSrc codes
package mips_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EXE  = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      C_ALU     = 3'd0,
      C_LOAD    = 3'd1,
      C_STORE   = 3'd2,
      C_BRANCH  = 3'd3,
      C_JUMP    = 3'd4,
      C_HALT    = 3'd5,
      C_ILLEGAL = 3'd6
   } iclass_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_SLL = 6'b000000;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_SLL = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_AND = 4'b0100;
   localparam logic [3:0] ALU_SLT = 4'b0101;

   localparam logic [1:0] PC_SEQ    = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode/funct decode into instruction class and static controls
module ctrl_decode
   import mips_ctrl_pkg::*;
#(
   parameter int OP_W = 6
) (
   input  logic [OP_W-1:0] opcode,
   input  logic [OP_W-1:0] funct,
   output iclass_t         iclass,
   output logic [3:0]      alu_op,
   output logic            alu_src_a,
   output logic            alu_src_b,
   output logic            ext_sel,
   output logic            reg_dst,
   output logic            db_data_src
);

   always_comb begin
      iclass      = C_ILLEGAL;
      alu_op      = ALU_ADD;
      alu_src_a   = 1'b0;
      alu_src_b   = 1'b0;
      ext_sel     = 1'b1;
      reg_dst     = 1'b0;
      db_data_src = 1'b0;
      case (opcode)
         OP_W'(OP_RTYPE): begin
            reg_dst = 1'b1;
            iclass  = C_ALU;
            case (funct)
               OP_W'(FN_ADD): alu_op = ALU_ADD;
               OP_W'(FN_SUB): alu_op = ALU_SUB;
               OP_W'(FN_AND): alu_op = ALU_AND;
               OP_W'(FN_OR):  alu_op = ALU_OR;
               OP_W'(FN_SLT): alu_op = ALU_SLT;
               OP_W'(FN_SLL): begin
                  alu_op    = ALU_SLL;
                  alu_src_a = 1'b1;
               end
               default:       iclass = C_ILLEGAL;
            endcase
         end
         OP_W'(OP_ADDI): begin
            iclass    = C_ALU;
            alu_src_b = 1'b1;
         end
         OP_W'(OP_ORI): begin
            iclass    = C_ALU;
            alu_op    = ALU_OR;
            alu_src_b = 1'b1;
            ext_sel   = 1'b0;
         end
         OP_W'(OP_LW): begin
            iclass      = C_LOAD;
            alu_src_b   = 1'b1;
            db_data_src = 1'b1;
         end
         OP_W'(OP_SW): begin
            iclass    = C_STORE;
            alu_src_b = 1'b1;
         end
         OP_W'(OP_BEQ),
         OP_W'(OP_BNE): begin
            iclass = C_BRANCH;
            alu_op = ALU_SUB;
         end
         OP_W'(OP_J):    iclass = C_JUMP;
         OP_W'(OP_HALT): iclass = C_HALT;
         default:        iclass = C_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle CPU control FSM (IF/ID/EXE/MEM/WB/HALT)
// Optional trap on undefined instructions: ILLEGAL_OP_TRAP_EN.
module multi_cycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int ALUOP_W = 4,
   parameter int OP_W    = 6
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic [OP_W-1:0]    opcode,
   input  logic [OP_W-1:0]    funct,
   input  logic               zero,
   output logic               PCWre,
   output logic               IRWre,
   output logic               InsMemRW,
   output logic               ALUSrcA,
   output logic               ALUSrcB,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic               ExtSel,
   output logic               RegDst,
   output logic               RegWre,
   output logic               DBDataSrc,
   output logic               mRD,
   output logic               mWR,
   output logic [1:0]         PCSrc,
`ifdef ILLEGAL_OP_TRAP_EN
   output logic               illegal_op,
`endif
   output logic               halted
);

   state_t     state_q, state_d;
   logic       halted_q, halted_d;
`ifdef ILLEGAL_OP_TRAP_EN
   logic       illegal_q, illegal_d;
`endif

   iclass_t    iclass;
   logic [3:0] alu_op;
   logic       alu_src_a, alu_src_b, ext_sel, reg_dst, db_data_src;

   logic       pc_wre, ir_wre, ins_mem_rw, reg_wre, m_rd, m_wr, sel_en;
   logic [1:0] pc_src;
   logic       branch_taken;

   ctrl_decode #(.OP_W(OP_W)) u_decode (
      .opcode      (opcode),
      .funct       (funct),
      .iclass      (iclass),
      .alu_op      (alu_op),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .ext_sel     (ext_sel),
      .reg_dst     (reg_dst),
      .db_data_src (db_data_src)
   );

   assign branch_taken = (opcode == OP_W'(OP_BNE)) ? ~zero : zero;

   always_comb begin
      state_d    = state_q;
      pc_wre     = 1'b0;
      ir_wre     = 1'b0;
      ins_mem_rw = 1'b0;
      reg_wre    = 1'b0;
      m_rd       = 1'b0;
      m_wr       = 1'b0;
      pc_src     = PC_SEQ;
      sel_en     = 1'b0;
      case (state_q)
         S_IF: begin
            ir_wre     = 1'b1;
            ins_mem_rw = 1'b1;
            state_d    = S_ID;
         end
         S_ID: begin
            sel_en = 1'b1;
            case (iclass)
               C_JUMP: begin
                  pc_wre  = 1'b1;
                  pc_src  = PC_JUMP;
                  state_d = S_IF;
               end
               C_HALT: state_d = S_HALT;
               C_ILLEGAL: begin
`ifdef ILLEGAL_OP_TRAP_EN
                  state_d = S_HALT;
`else
                  // Unknown instruction retires as a NOP straight from decode
                  pc_wre  = 1'b1;
                  state_d = S_IF;
`endif
               end
               default: state_d = S_EXE;
            endcase
         end
         S_EXE: begin
            sel_en = 1'b1;
            case (iclass)
               C_ALU:   state_d = S_WB;
               C_LOAD,
               C_STORE: state_d = S_MEM;
               C_BRANCH: begin
                  pc_wre  = 1'b1;
                  pc_src  = branch_taken ? PC_BRANCH : PC_SEQ;
                  state_d = S_IF;
               end
               default: state_d = S_IF;
            endcase
         end
         S_MEM: begin
            sel_en = 1'b1;
            if (iclass == C_LOAD) begin
               m_rd    = 1'b1;
               state_d = S_WB;
            end else begin
               m_wr    = 1'b1;
               pc_wre  = 1'b1;
               state_d = S_IF;
            end
         end
         S_WB: begin
            sel_en  = 1'b1;
            reg_wre = 1'b1;
            pc_wre  = 1'b1;
            state_d = S_IF;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IF;
      endcase
      halted_d = (state_d == S_HALT);
   end

`ifdef ILLEGAL_OP_TRAP_EN
   assign illegal_d = illegal_q | ((state_q == S_ID) && (iclass == C_ILLEGAL));
`endif

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q   <= S_IF;
         halted_q  <= 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         halted_q  <= halted_d;
`ifdef ILLEGAL_OP_TRAP_EN
         illegal_q <= illegal_d;
`endif
      end
   end

   // Reset is folded in combinationally so enables drop the moment Reset falls
   assign PCWre     = Reset & pc_wre;
   assign IRWre     = Reset & ir_wre;
   assign InsMemRW  = Reset & ins_mem_rw;
   assign RegWre    = Reset & reg_wre;
   assign mRD       = Reset & m_rd;
   assign mWR       = Reset & m_wr;
   assign PCSrc     = Reset ? pc_src : PC_SEQ;

   assign ALUSrcA   = Reset & sel_en & alu_src_a;
   assign ALUSrcB   = Reset & sel_en & alu_src_b;
   assign ExtSel    = Reset & sel_en & ext_sel;
   assign RegDst    = Reset & sel_en & reg_dst;
   assign DBDataSrc = Reset & sel_en & db_data_src;
   assign ALUOp     = (Reset & sel_en) ? ALUOP_W'(alu_op) : '0;

   assign halted    = halted_q;
`ifdef ILLEGAL_OP_TRAP_EN
   assign illegal_op = illegal_q;
`endif

endmodule
